// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (piso_serializer transmit end, sipo_register receive end).
package serial_pkg;

    // Default word width used by both ends of the link.
    localparam int unsigned SER_DEFAULT_WIDTH = 4;

    // Transmitter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage : serial_pkg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit per
// clock, MSB or LSB first. A word offered during the last bit of the current
// word is accepted and follows with no idle cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_valid    p_in holds a word to send
//   load_ready    a word can be accepted this cycle
//   p_in          parallel word, sampled on load_valid && load_ready
//   serial_out    current serial bit (0 when serial_valid is low)
//   serial_valid  serial_out carries a data bit
//   frame_start   first bit of a word
//   done          last bit of a word
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign accept   = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an accept on the last bit keeps us in SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state, shift register and bit counter.
    always_comb begin
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        frame_start  = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                load_ready   = last_bit;
                serial_valid = 1'b1;
                serial_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                frame_start  = (cnt == '0);
                done         = (cnt == CNT_LAST);
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, otherwise shift toward the output end while sending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= p_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            // Clear instead of wrapping when the word ends without a follow-on.
            cnt <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first
// instance share the same stimulus; accepted words are expanded into
// per-bit expectations and compared by an independent negedge monitor.
module tb_piso_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] p_in = '0;

    // index 0: MSB-first instance, index 1: LSB-first instance
    logic [1:0] lr, so, sv, fs, dn;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[0]),
        .p_in(p_in), .serial_out(so[0]), .serial_valid(sv[0]),
        .frame_start(fs[0]), .done(dn[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[1]),
        .p_in(p_in), .serial_out(so[1]), .serial_valid(sv[1]),
        .frame_start(fs[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        bit bm;   // expected bit, MSB-first instance
        bit bl;   // expected bit, LSB-first instance
        bit fs;
        bit dn;
    } exp_t;

    exp_t q[$];
    bit   exp_ready = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Scoreboard producer: a word is taken whenever the source offers it and
    // the link is free (idle, or the word in flight is on its last bit).
    always @(posedge clk) begin
        if (rst_n && load_valid && exp_ready) begin
            for (int i = 0; i < int'(W); i++) begin
                exp_t e;
                e.bm = p_in[W-1-i];
                e.bl = p_in[i];
                e.fs = (i == 0);
                e.dn = (i == int'(W) - 1);
                q.push_back(e);
            end
        end
    end

    // Monitor: every cycle either the next expected bit is on the line or the line is idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_ready = 1'b1;
            check("rst_valid", sv, 2'b00);
            check("rst_out", so, 2'b00);
            check("rst_ready", lr, 2'b11);
            check("rst_fs_done", {fs[0] | dn[0], fs[1] | dn[1]}, 2'b00);
        end else begin
            bit er;
            er = (q.size() <= 1);
            check("load_ready", lr, {er, er});
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("serial_valid", sv, 2'b11);
                check("serial_out", so, {e.bl, e.bm});
                check("frame_start", fs, {e.fs, e.fs});
                check("done", dn, {e.dn, e.dn});
            end else begin
                check("idle_valid", sv, 2'b00);
                check("idle_out", so, 2'b00);
                check("idle_fs_done", fs | dn, 2'b00);
            end
            exp_ready = er;
        end
    end

    // Inputs change shortly after the negedge and hold through the next posedge.
    task automatic drive(input logic lv, input logic [W-1:0] p);
        @(negedge clk);
        #2;
        load_valid = lv;
        p_in       = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom));
    endtask

    initial begin
        // reset with load_valid low
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // single words: 1001 and 0011 (both bit orders checked on each)
        drive(1'b1, 4'b1001);
        idle(5);
        drive(1'b1, 4'b0011);
        idle(5);

        // back-to-back A then 5, 5 held from the first bit of A
        drive(1'b1, 4'hA);
        repeat (4) drive(1'b1, 4'h5);
        idle(5);

        // F pulsed while 0 is in flight is ignored
        drive(1'b1, 4'h0);
        drive(1'b0, 4'h0);
        drive(1'b1, 4'hF);
        drive(1'b0, 4'h0);
        idle(4);

        // asynchronous reset in the middle of C, then 3 as a fresh frame
        drive(1'b1, 4'hC);
        drive(1'b0, 4'h0);
        drive(1'b0, 4'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 4'h3);
        idle(6);

        // random traffic with changing p_in and occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            drive(1'b1 && ($urandom_range(0, 3) != 0), W'($urandom));
        end

        idle(W + 4);
        check("drain", {1'b0, q.size() == 0}, 2'b01);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_piso_serializer
